ssd_digit_scanner: RTL

Time-multiplexed scan controller for an N-digit common-anode seven-segment display. It holds a packed N-nibble display value, steps through the digits at a programmable refresh rate, and drives one anode at a time. It also presents the active digit's nibble on hex_out, which feeds the selectHex input of the downstream hex-to-segment decoder. It adds anti-ghosting blanking, tear-free frame-synchronous updates and optional leading-zero suppression.

---
 rtl/ssd_pkg.sv | 21 ++
 rtl/ssd_digit_scanner_slot_timer.sv | 39 +++
 rtl/ssd_digit_scanner.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared types and helpers for the seven-segment digit scanner.
package ssd_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scanState_t;

  // Level that lights / darkens one anode line for the given polarity.
  function automatic logic ANODE_ON(input bit activeLow);
    return activeLow ? 1'b0 : 1'b1;
  endfunction

  function automatic logic ANODE_OFF(input bit activeLow);
    return activeLow ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/ssd_digit_scanner_slot_timer.sv
// Free-running slot counter: 0..REFRESH_DIV-1, held at zero while cleared.
module ssd_slot_timer
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic blankEnd,
  output logic slotEnd
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cntReg;

  assign slotEnd = !clear && (cntReg == CNT_W'(REFRESH_DIV - 1));

  generate
    if (BLANK_CYCLES > 0) begin : gBlank
      assign blankEnd = !clear && (cntReg == CNT_W'(BLANK_CYCLES - 1));
    end else begin : gNoBlank
      assign blankEnd = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntReg <= '0;
    end else if (clear || slotEnd) begin
      cntReg <= '0;
    end else begin
      cntReg <= cntReg + 1'b1;
    end
  end

endmodule

// File: rtl/ssd_digit_scanner.sv
// Multiplexed scan controller for an N-digit common-anode display with
// blanking, frame-synchronous updates and leading-zero suppression.
module ssd_digit_scanner
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int BLANK_CYCLES     = 500,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0]   value_in,
  input  logic                             load,
  input  logic                             blank_lz,
  output logic [NIBBLE_W-1:0]              hex_out,
  output logic [NUM_DIGITS-1:0]            anode,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                             frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;
  localparam bit ACT_LOW = (ANODE_ACTIVE_LOW != 0);
  localparam scanState_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scanState_t stateReg, stateNext;
  logic [IDX_W-1:0]      digitIdxReg, idxNext;
  logic [VAL_W-1:0]      shadowReg, displayReg, displayNext;
  logic [NIBBLE_W-1:0]   hexOutReg, hexNext;
  logic [NUM_DIGITS-1:0] anodeReg, anodeNext;
  logic                  frameDoneReg, frameDoneNext;
  logic                  blankEnd, slotEnd, wrap, boundary;
  logic [NIBBLE_W-1:0]   nibbles [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] nibbleZero, suppress;

  ssd_slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) uSlotTimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (stateReg == IDLE),
    .blankEnd(blankEnd),
    .slotEnd (slotEnd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateReg <= IDLE;
    else        stateReg <= stateNext;
  end

  always_comb begin
    stateNext = stateReg;
    idxNext   = digitIdxReg;
    wrap      = 1'b0;
    boundary  = 1'b0;
    case (stateReg)
      IDLE: begin
        idxNext = '0;
        if (enable) begin
          stateNext = SLOT_START;
          boundary  = 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          stateNext = IDLE;
          idxNext   = '0;
        end else if (blankEnd) begin
          stateNext = SHOW;
        end
      end
      SHOW: begin
        if (!enable) begin
          stateNext = IDLE;
          idxNext   = '0;
        end else if (slotEnd) begin
          stateNext = SLOT_START;
          if (digitIdxReg == LAST_IDX) begin
            idxNext  = '0;
            wrap     = 1'b1;
            boundary = 1'b1;
          end else begin
            idxNext = digitIdxReg + 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        idxNext   = '0;
      end
    endcase
  end

  // A load coincident with the boundary bypasses the shadow.
  assign displayNext = boundary ? (load ? value_in : shadowReg) : displayReg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : gDigit
      assign nibbles[gi]    = displayNext[gi*NIBBLE_W +: NIBBLE_W];
      assign nibbleZero[gi] = (nibbles[gi] == '0);
      assign suppress[gi]   = blank_lz && (gi != 0) && (&nibbleZero[NUM_DIGITS-1:gi]);
      assign anodeNext[gi]  = (stateNext == SHOW && idxNext == IDX_W'(gi) && !suppress[gi])
                              ? ANODE_ON(ACT_LOW) : ANODE_OFF(ACT_LOW);
    end
  endgenerate

  always_comb begin
    hexNext       = '0;
    frameDoneNext = wrap;
    if (stateNext != IDLE) hexNext = nibbles[idxNext];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadowReg    <= '0;
      displayReg   <= '0;
      digitIdxReg  <= '0;
      hexOutReg    <= '0;
      anodeReg     <= {NUM_DIGITS{ANODE_OFF(ACT_LOW)}};
      frameDoneReg <= 1'b0;
    end else begin
      if (load) shadowReg <= value_in;
      displayReg   <= displayNext;
      digitIdxReg  <= idxNext;
      hexOutReg    <= hexNext;
      anodeReg     <= anodeNext;
      frameDoneReg <= frameDoneNext;
    end
  end

  assign hex_out    = hexOutReg;
  assign anode      = anodeReg;
  assign digit_idx  = digitIdxReg;
  assign frame_done = frameDoneReg;

endmodule
